// File: rtl/rns4_to_bin_mrc_pkg.sv
// Shared constants for the {107,109,113,127} residue-to-binary converter:
// moduli, widths, the mixed-radix inverse table and the FSM encoding.
package rns4_pkg;

    localparam int RW = 7;
    localparam int XW = 28;

    localparam logic [RW-1:0] M1 = 7'd107;
    localparam logic [RW-1:0] M2 = 7'd109;
    localparam logic [RW-1:0] M3 = 7'd113;
    localparam logic [RW-1:0] M4 = 7'd127;

    localparam logic [XW-1:0] M_ALL = 28'd167375713;

    // inv(m_j mod m_i) mod m_i, named INV_<i><j>
    localparam logic [RW-1:0] INV_21 = 7'd54;
    localparam logic [RW-1:0] INV_31 = 7'd94;
    localparam logic [RW-1:0] INV_32 = 7'd28;
    localparam logic [RW-1:0] INV_41 = 7'd19;
    localparam logic [RW-1:0] INV_42 = 7'd7;
    localparam logic [RW-1:0] INV_43 = 7'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MRC  = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_M2 = 2'd0,
        SEL_M3 = 2'd1,
        SEL_M4 = 2'd2
    } msel_e;

    function automatic logic [RW-1:0] modulus_of(input msel_e sel);
        case (sel)
            SEL_M2:  modulus_of = M2;
            SEL_M3:  modulus_of = M3;
            default: modulus_of = M4;
        endcase
    endfunction

endpackage

// File: rtl/rns4_to_bin_mrc_step.sv
// One mixed-radix step: ((t - a) mod m) * inv mod m, with m picked from
// the three target moduli. Purely combinational, shared by all MRC steps.
module mrc_step
    import rns4_pkg::*;
(
    input  logic [RW-1:0] t,
    input  logic [RW-1:0] a,
    input  msel_e         m_sel,
    input  logic [RW-1:0] inv,
    output logic [RW-1:0] r
);

    logic [RW-1:0]   m;
    logic [RW:0]     diff;
    logic [2*RW:0]   prod;

    always_comb begin
        m    = modulus_of(m_sel);
        diff = (t >= a) ? ({1'b0, t} - {1'b0, a})
                        : ({1'b0, t} + {1'b0, m} - {1'b0, a});
        prod = (2*RW+1)'(diff) * (2*RW+1)'(inv);
        // Constant divisors per branch keep each reduction a fixed-modulus circuit
        case (m_sel)
            SEL_M2:  r = RW'(prod % (2*RW+1)'(M2));
            SEL_M3:  r = RW'(prod % (2*RW+1)'(M3));
            default: r = RW'(prod % (2*RW+1)'(M4));
        endcase
    end

endmodule

// File: rtl/rns4_to_bin_mrc.sv
// Residue-to-binary converter for RNS {107,109,113,127}: six sequential
// mixed-radix steps, three Horner steps, then a registered result.
module rns4_to_bin_mrc
    import rns4_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [RW-1:0] i_r1,
    input  logic [RW-1:0] i_r2,
    input  logic [RW-1:0] i_r3,
    input  logic [RW-1:0] i_r4,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [XW-1:0] o_x,
    output logic          o_err
);

    state_e        state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [RW-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d, t4_q, t4_d;
    logic          err_q, err_d;
    logic [XW-1:0] acc_q, acc_d;
    logic          i_ready_q, i_ready_d;
    logic          o_valid_q, o_valid_d;
    logic [XW-1:0] o_x_q, o_x_d;
    logic          o_err_q, o_err_d;

    logic [RW-1:0] step_t, step_a, step_inv, step_r;
    msel_e         step_m;
    logic [XW-1:0] horner_base, horner_next;
    logic [RW-1:0] horner_mult, horner_add;

    // MRC pair schedule: (2,1),(3,1),(4,1),(3,2),(4,2),(4,3)
    always_comb begin
        step_t   = t4_q;
        step_a   = t3_q;
        step_m   = SEL_M4;
        step_inv = INV_43;
        case (step_q)
            3'd0: begin step_t = t2_q; step_a = t1_q; step_m = SEL_M2; step_inv = INV_21; end
            3'd1: begin step_t = t3_q; step_a = t1_q; step_m = SEL_M3; step_inv = INV_31; end
            3'd2: begin step_t = t4_q; step_a = t1_q; step_m = SEL_M4; step_inv = INV_41; end
            3'd3: begin step_t = t3_q; step_a = t2_q; step_m = SEL_M3; step_inv = INV_32; end
            3'd4: begin step_t = t4_q; step_a = t2_q; step_m = SEL_M4; step_inv = INV_42; end
            default: ;
        endcase
    end

    mrc_step u_step (
        .t     (step_t),
        .a     (step_a),
        .m_sel (step_m),
        .inv   (step_inv),
        .r     (step_r)
    );

    always_comb begin
        horner_base = acc_q;
        horner_mult = M1;
        horner_add  = t1_q;
        case (step_q)
            3'd0: begin horner_base = XW'(t4_q); horner_mult = M3; horner_add = t3_q; end
            3'd1: begin horner_mult = M2; horner_add = t2_q; end
            default: ;
        endcase
        horner_next = horner_base * XW'(horner_mult) + XW'(horner_add);
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        t1_d      = t1_q;
        t2_d      = t2_q;
        t3_d      = t3_q;
        t4_d      = t4_q;
        err_d     = err_q;
        acc_d     = acc_q;
        i_ready_d = i_ready_q;
        o_valid_d = o_valid_q;
        o_x_d     = o_x_q;
        o_err_d   = o_err_q;
        case (state_q)
            ST_IDLE: begin
                i_ready_d = 1'b1;
                if (i_valid && i_ready_q) begin
                    t1_d      = i_r1;
                    t2_d      = i_r2;
                    t3_d      = i_r3;
                    t4_d      = i_r4;
                    err_d     = (i_r1 >= M1) || (i_r2 >= M2) || (i_r3 >= M3) || (i_r4 >= M4);
                    i_ready_d = 1'b0;
                    step_d    = 3'd0;
                    state_d   = ST_MRC;
                end
            end
            ST_MRC: begin
                case (step_q)
                    3'd0:       t2_d = step_r;
                    3'd1, 3'd3: t3_d = step_r;
                    default:    t4_d = step_r;
                endcase
                if (step_q == 3'd5) begin
                    step_d  = 3'd0;
                    state_d = ST_ACC;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_ACC: begin
                // Three Horner steps, then one cycle to register the result
                if (step_q < 3'd3) begin
                    acc_d  = horner_next;
                    step_d = step_q + 3'd1;
                end else begin
                    o_x_d     = err_q ? '0 : acc_q;
                    o_err_d   = err_q;
                    o_valid_d = 1'b1;
                    step_d    = 3'd0;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                if (o_ready) begin
                    o_valid_d = 1'b0;
                    i_ready_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            t1_q      <= '0;
            t2_q      <= '0;
            t3_q      <= '0;
            t4_q      <= '0;
            err_q     <= 1'b0;
            acc_q     <= '0;
            i_ready_q <= 1'b0;
            o_valid_q <= 1'b0;
            o_x_q     <= '0;
            o_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            t3_q      <= t3_d;
            t4_q      <= t4_d;
            err_q     <= err_d;
            acc_q     <= acc_d;
            i_ready_q <= i_ready_d;
            o_valid_q <= o_valid_d;
            o_x_q     <= o_x_d;
            o_err_q   <= o_err_d;
        end
    end

    assign i_ready = i_ready_q;
    assign o_valid = o_valid_q;
    assign o_x     = o_x_q;
    assign o_err   = o_err_q;

endmodule
